wb_stage: RTL

- MEM/WB pipeline register plus load-data alignment for the 5-stage MIPS core.
- Captures the MEM-stage result at posedge and presents waddr/wdata/we to the register file write port.
- The register file commits on the following negedge, so a write lands within the WB cycle.
- The same registered outputs drive the ID-stage forwarding path.

---
 rtl/wb_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register with big-endian load-data alignment.
// Captures the MEM-stage result on posedge and drives the register-file write
// port (committed on the following negedge) and the ID-stage forwarding path.
// Optional build macro WB_RETIRE_CNT_EN adds a 32-bit retired-write counter.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [2:0]        mem_load_op,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_misalign
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  // Load operation encodings; 6 and 7 are reserved and behave like "none".
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LB   = 3'd1;
  localparam logic [2:0] OP_LBU  = 3'd2;
  localparam logic [2:0] OP_LH   = 3'd3;
  localparam logic [2:0] OP_LHU  = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;

  logic              we_reg, we_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              misalign_reg, misalign_next;

  // Byte lanes in big-endian order: lane 0 is the most significant byte.
  logic [7:0]  byte_lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        misaligned;
  logic        capture;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = mem_rdata[DATA_W-1-8*gi -: 8];
    end
  endgenerate

  assign sel_byte = byte_lane[mem_addr_lo];
  assign sel_half = mem_addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];

  // Halfword loads need an even address, word loads a word-aligned one.
  assign misaligned = (((mem_load_op == OP_LH) || (mem_load_op == OP_LHU)) && mem_addr_lo[0]) ||
                      ((mem_load_op == OP_LW) && (mem_addr_lo != 2'd0));

  // A new instruction enters WB only when nothing flushes, holds or bubbles it.
  assign capture = !flush && !stall_wb && !stall_mem;

  // Next-state computation: lane select/extend, misalignment drop, r0 squash.
  always_comb begin
    we_next       = 1'b0;
    waddr_next    = mem_waddr;
    wdata_next    = mem_result;
    misalign_next = 1'b0;
    case (mem_load_op)
      OP_LB:  wdata_next = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      OP_LBU: wdata_next = {{(DATA_W-8){1'b0}}, sel_byte};
      OP_LH:  wdata_next = {{(DATA_W-16){sel_half[15]}}, sel_half};
      OP_LHU: wdata_next = {{(DATA_W-16){1'b0}}, sel_half};
      OP_LW:  wdata_next = mem_rdata;
      default: wdata_next = mem_result;
    endcase
    if (misaligned) begin
      wdata_next    = '0;
      misalign_next = 1'b1;
    end
    we_next = mem_wreg && !misaligned && (mem_waddr != '0);
  end

  // Pipeline register: reset > flush > stall_wb hold > stall_mem bubble > capture.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      we_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      misalign_reg <= 1'b0;
    end else if (stall_wb) begin
      we_reg       <= we_reg;
      waddr_reg    <= waddr_reg;
      wdata_reg    <= wdata_reg;
      misalign_reg <= misalign_reg;
    end else if (stall_mem) begin
      we_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      misalign_reg <= 1'b0;
    end else begin
      we_reg       <= we_next;
      waddr_reg    <= waddr_next;
      wdata_reg    <= wdata_next;
      misalign_reg <= misalign_next;
    end
  end

  assign wb_we       = we_reg;
  assign wb_waddr    = waddr_reg;
  assign wb_wdata    = wdata_reg;
  assign wb_misalign = misalign_reg;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_reg;

  // Count every newly captured register-file write; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_reg <= '0;
    end else if (capture && we_next) begin
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_reg;
`else
  // Without the counter the capture qualifier has no consumer.
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule
